// File: rtl/parity_stream_gen.sv
// parity_stream_gen: parity generate/check stage behind a 2-entry FIFO with delivery statistics.
module parity_stream_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              chk_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  logic [1:0]      state;
  logic            run;
  logic [DATA_W:0] d0, d1, nd;
  logic            e0, e1, ne, acc, dlv;
  always_comb begin
    nd = chk_mode ? in_data : {^in_data[DATA_W-1:0] ^ odd_mode, in_data[DATA_W-1:0]};
    ne = chk_mode & (^in_data ^ odd_mode);
  end
  // run holds in_ready low until the first edge after reset release
  assign in_ready  = run && state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data  = d0;
  assign out_err   = e0;
  assign acc       = in_valid & in_ready;
  assign dlv       = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      run   <= 1'b0;
      d0    <= '0;
      d1    <= '0;
      e0    <= 1'b0;
      e1    <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state + 2'(acc) - 2'(dlv);
      if (dlv) begin
        d0 <= d1;
        e0 <= e1;
      end
      if (acc && (state == EMPTY || dlv)) begin
        d0 <= nd;
        e0 <= ne;
      end else if (acc) begin
        d1 <= nd;
        e1 <= ne;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      err_count  <= '0;
    end else if (clr_cnt) begin
      word_count <= '0;
      err_count  <= '0;
    end else if (dlv) begin
      word_count <= word_count + 1'b1;
      if (e0 && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: doc/parity_stream_gen.md
PARITY_STREAM_GEN -- requirements
Module: parity_stream_gen

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range is 1 to 64.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters; legal range is 2 to 32.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset: asynchronous assertion, active-low, with synchronous-to-clk deassertion supplied externally.
REQ-005 Port odd_mode  input  1  parity sense: 0 = even, 1 = odd; sampled with each accepted word.
REQ-006 Port chk_mode  input  1  operating mode: 0 = generate, 1 = check; sampled with each accepted word.
REQ-007 Port in_valid  input  1  upstream word present.
REQ-008 Port in_ready  output  1  block can accept a word.
REQ-009 Port in_data  input  DATA_W+1  bits [DATA_W-1:0] are the payload; bit DATA_W is the received parity, used in check mode only.
REQ-010 Port out_valid  output  1  downstream word present.
REQ-011 Port out_ready  input  1  downstream accepts the word.
REQ-012 Port out_data  output  DATA_W+1  the word as {parity, payload}.
REQ-013 Port out_err  output  1  parity-error flag for the word currently on out_data.
REQ-014 Port clr_cnt  input  1  synchronous clear of both counters.
REQ-015 Port word_count  output  CNT_W  count of words delivered; wraps.
REQ-016 Port err_count  output  CNT_W  count of errored words delivered; saturates.

Function
REQ-017 A word is accepted on a rising edge where in_valid=1 and in_ready=1; it is delivered on a rising edge where out_valid=1 and out_ready=1.
REQ-018 Buffering is a 2-entry FIFO with occupancy states EMPTY, ONE and TWO:
- accept only: state +1
- deliver only: state -1
- accept and deliver together: state unchanged
- neither: state unchanged
REQ-019 in_ready shall be 1 exactly when the state is EMPTY or ONE, driven from registered state only; there is no combinational path from out_ready to in_ready.
REQ-020 out_valid shall be 1 exactly when the state is ONE or TWO; out_data and out_err always show the oldest entry.
REQ-021 Latency: a word accepted into an EMPTY buffer appears on out_valid on the cycle after the accepting edge; sustained throughput is 1 word per cycle while out_ready=1.
REQ-022 Generate mode:
- stored parity = (XOR of payload) XOR odd_mode
- out_data = {stored parity, payload}
- out_err = 0
REQ-023 Check mode:
- out_data = in_data unchanged
- out_err = (XOR of all DATA_W+1 bits) XOR odd_mode
- i.e. an error is an odd total under even sense, or an even total under odd sense
REQ-024 odd_mode and chk_mode are captured per word at acceptance; changing them later does not affect buffered words.
REQ-025 Word order is strictly FIFO; no word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 out_data and out_err shall hold stable while out_valid=1 and out_ready=0.
REQ-027 word_count increments by 1 on each delivery and wraps from all-ones to 0.
REQ-028 err_count increments by 1 on each delivery with out_err=1 and holds at all-ones once reached.
REQ-029 clr_cnt=1 zeroes both counters on that edge and takes priority over a same-edge increment; the FIFO is not affected.
REQ-030 When DATA_W=1, the parity of a 1-bit payload is the bit itself XOR odd_mode; no special case is required.

Reset
REQ-031 While rst_n=0, the following hold immediately and asynchronously:
- state EMPTY
- out_valid=0, out_data=0, out_err=0
- in_ready=0
- word_count=0, err_count=0
REQ-032 in_ready rises on the first rising edge after rst_n deasserts; no word is accepted on that edge.
REQ-033 Reset asserted mid-operation discards all buffered words; none are delivered after reset.

Verification
REQ-034 Generate, DATA_W=8, out_ready=1: in_data=0x0A5 with odd_mode=0 gives out_data=0x0A5 and out_err=0; with odd_mode=1 it gives 0x1A5; in_data=0x007 with odd_mode=0 gives 0x107.
REQ-035 Check, odd_mode=0: in_data=0x107 gives out_err=0; 0x007 gives out_err=1 and err_count=1; with odd_mode=1, 0x007 gives out_err=0.
REQ-036 Backpressure: out_ready=0 and three back-to-back words W0, W1, W2 give in_ready=0 after W1 with W2 held upstream; raising out_ready then delivers W0, W1, W2 in order on consecutive cycles, with word_count=3.
REQ-037 Counter limits, CNT_W=4: 17 errored deliveries give err_count=15 and word_count=1; clr_cnt on the same edge as a delivery leaves both counters at 0.
REQ-038 Mid-operation reset: with the buffer holding 2 words, asserting rst_n=0 drops out_valid to 0 and both counters to 0 without waiting for a clock edge; after release, out_valid stays 0 until a new word is accepted.
REQ-039 Mode capture: accept a word in generate mode, switch to chk_mode=1 before delivery; the delivered word shall show generate-mode parity and out_err=0.
